// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext,brk,code} key events
// and queues them in a first-word-fall-through FIFO.
module ps2_key_event_decoder #(
   parameter int unsigned FIFO_AW     = 2,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] din,
   input  logic       rd_en,
   input  logic       clr_ovf,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_brk,
   output logic       empty,
   output logic       full,
   output logic       overflow
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0]      TMAX  = CW'(TIMEOUT_CYC - 1);
   localparam logic [FIFO_AW:0]   CFULL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      tmo_q, tmo_d;
   logic [9:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ovf_q;
   logic               emit;
   logic [9:0]         ev;
   logic               do_pop, do_push;

   function automatic logic is_hk(input logic [7:0] b);
      return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
   endfunction

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      emit    = 1'b0;
      ev      = {(state_q == S_E0) || (state_q == S_E0F0),
                 (state_q == S_F0) || (state_q == S_E0F0), din};
      if (rx_done_tick) begin
         tmo_d = '0;
         if (din == 8'hE0) begin
            state_d = S_E0;
         end else if (din == 8'hF0) begin
            state_d = ((state_q == S_E0) || (state_q == S_E0F0)) ? S_E0F0 : S_F0;
         end else if (is_hk(din)) begin
            state_d = S_IDLE;
         end else begin
            emit    = 1'b1;
            state_d = S_IDLE;
         end
      end else if (state_q == S_IDLE) begin
         tmo_d = '0;
      end else if (tmo_q == TMAX) begin
         state_d = S_IDLE;
         tmo_d   = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == CFULL);
   // A full FIFO still accepts a write when the same edge pops the head slot.
   assign do_pop  = rd_en && !empty;
   assign do_push = emit && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         tmo_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         count_q <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= ev;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (emit && !do_push) ovf_q <= 1'b1;
         else if (clr_ovf)     ovf_q <= 1'b0;
      end
   end

   assign {key_ext, key_brk, key_code} = mem_q[rd_ptr_q];
   assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder: prefix-flag model with an event
// queue checked every cycle, plus literal expectations for each scenario.
module tb_ps2_key_event_decoder;

   localparam int unsigned AW  = 2;
   localparam int unsigned DEP = 4;
   localparam int unsigned T   = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_done_tick = 1'b0;
   logic [7:0] din = '0;
   logic       rd_en = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [7:0] key_code;
   logic       key_ext, key_brk, empty, full, overflow;

   int total = 0;
   int bad   = 0;

   ps2_key_event_decoder #(.FIFO_AW(AW), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
      .rd_en(rd_en), .clr_ovf(clr_ovf), .key_code(key_code), .key_ext(key_ext),
      .key_brk(key_brk), .empty(empty), .full(full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: pending prefix as two flags, events as a plain queue.
   logic [9:0] mq[$];
   bit m_ext, m_brk, m_ovf;
   int cyc, last_tick;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_ext = 0; m_brk = 0; m_ovf = 0;
         cyc = 0; last_tick = 0;
      end else begin
         bit em, dropped;
         logic [9:0] e;
         em = 0; dropped = 0; e = '0;
         cyc++;
         if (rx_done_tick) begin
            if (cyc - last_tick > T) begin m_ext = 0; m_brk = 0; end
            last_tick = cyc;
            case (din)
               8'hE0: begin m_ext = 1; m_brk = 0; end
               8'hF0: m_brk = 1;
               8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin m_ext = 0; m_brk = 0; end
               default: begin em = 1; e = {m_ext, m_brk, din}; m_ext = 0; m_brk = 0; end
            endcase
         end
         if (rd_en && mq.size() > 0) void'(mq.pop_front());
         if (em) begin
            if (mq.size() < DEP) mq.push_back(e);
            else dropped = 1;
         end
         if (dropped) m_ovf = 1;
         else if (clr_ovf) m_ovf = 0;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("empty", int'(empty), int'(mq.size() == 0));
         chk("full", int'(full), int'(mq.size() == DEP));
         chk("overflow", int'(overflow), int'(m_ovf));
         if (mq.size() > 0) chk("head", int'({key_ext, key_brk, key_code}), int'(mq[0]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_done_tick = 1'b1; din = b;
      step();
      rx_done_tick = 1'b0; din = '0;
   endtask

   task automatic pop_expect(input string nm, input bit e, input bit b, input logic [7:0] c);
      chk({nm, "_nonempty"}, int'(empty), 0);
      chk(nm, int'({key_ext, key_brk, key_code}), int'({e, b, c}));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_head", int'({key_ext, key_brk, key_code}), 0);
      reset = 1'b1;
      step();

      // reset while an E0 prefix is pending
      send(8'hE0);
      #2 reset = 1'b0;
      #2 chk("midrst_empty", int'(empty), 1);
      chk("midrst_ovf", int'(overflow), 0);
      reset = 1'b1;
      step();
      send(8'h1C);
      pop_expect("after_rst", 0, 0, 8'h1C);

      // make / break, latency one clock
      send(8'h1C);
      chk("lat_empty", int'(empty), 0);
      send(8'hF0); send(8'h1C);
      pop_expect("make_1c", 0, 0, 8'h1C);
      pop_expect("brk_1c", 0, 1, 8'h1C);

      // extended make / break
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      pop_expect("ext_make", 1, 0, 8'h75);
      pop_expect("ext_brk", 1, 1, 8'h75);

      // housekeeping, stray prefixes, Pause byte
      send(8'hFA); send(8'hAA);
      step();
      chk("hk_empty", int'(empty), 1);
      send(8'hE0); send(8'hFA); send(8'h1C);
      pop_expect("hk_clears", 0, 0, 8'h1C);
      send(8'hF0); send(8'hE0); send(8'h6B);
      pop_expect("f0_e0", 1, 0, 8'h6B);
      send(8'hE1);
      pop_expect("pause", 0, 0, 8'hE1);

      // timeout boundary: T-1 idle clocks keeps prefix, T idle clocks drops it
      send(8'hF0);
      repeat (T - 1) step();
      send(8'h1C);
      pop_expect("tmo_keep", 0, 1, 8'h1C);
      send(8'hF0);
      repeat (T) step();
      send(8'h1C);
      pop_expect("tmo_drop", 0, 0, 8'h1C);

      // overflow with no reads
      for (int i = 0; i < 5; i++) send(8'h15 + 8'(i));
      chk("ovf_full", int'(full), 1);
      chk("ovf_set", int'(overflow), 1);
      for (int i = 0; i < 4; i++) pop_expect("ovf_pop", 0, 0, 8'h15 + 8'(i));
      chk("ovf_sticky", int'(overflow), 1);
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      chk("ovf_clr", int'(overflow), 0);

      // full FIFO, write and read in the same cycle
      for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
      rx_done_tick = 1'b1; din = 8'h24; rd_en = 1'b1;
      step();
      rx_done_tick = 1'b0; din = '0; rd_en = 1'b0;
      chk("pp_full", int'(full), 1);
      chk("pp_noovf", int'(overflow), 0);
      for (int i = 1; i < 5; i++) pop_expect("pp_pop", 0, 0, 8'h20 + 8'(i));
      chk("pp_empty", int'(empty), 1);

      // set wins over clear
      for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
      clr_ovf = 1'b1;
      send(8'h34);
      clr_ovf = 1'b0;
      chk("ovf_prio", int'(overflow), 1);
      for (int i = 0; i < 4; i++) pop_expect("prio_pop", 0, 0, 8'h30 + 8'(i));
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
